pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port stallreq_id  input  1  ID stage requests a stall.
REQ-004 SHALL have port stallreq_ex  input  1  EX multi-cycle ALU op is busy.
REQ-005 SHALL have port mem_busy  input  1  data memory access not yet complete.
REQ-006 SHALL have port flush_req  input  1  exception/redirect request, single-cycle pulse.
REQ-007 SHALL have port flush_pc  input  32  redirect target, valid with flush_req.
REQ-008 SHALL have ports id_reg1_read, id_reg2_read  input  1  ID source-operand read enables.
REQ-009 SHALL have ports id_reg1_addr, id_reg2_addr  input  5  ID source register numbers.
REQ-010 SHALL have port ex_is_load  input  1  instruction in EX is a load.
REQ-011 SHALL have port ex_wd  input  5  write destination of the instruction in EX.
REQ-012 SHALL have port stall  output  6  freeze vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-013 SHALL have port flush  output  1  clear all pipeline registers this cycle.
REQ-014 SHALL have port new_pc  output  32  PC to load while flush=1.
REQ-015 SHALL have port stall_cnt  output  32  cycles with stall[2]=1, saturating.
REQ-016 SHALL have port flush_cnt  output  16  accepted flushes, wrapping.

Function
REQ-017 Load-use hazard SHALL be asserted when ex_is_load=1, ex_wd!=0, and (id_reg1_read=1 and id_reg1_addr==ex_wd) or (id_reg2_read=1 and id_reg2_addr==ex_wd).
REQ-018 In RUN, stall SHALL be combinational with strict priority: mem_busy -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id or load-use -> 6'b000111; else 6'b000000.
REQ-019 FSM states SHALL be RUN, FLUSH_WAIT, FLUSH.
REQ-020 RUN with flush_req=1 and mem_busy=0 at a rising edge SHALL go to FLUSH and latch flush_pc.
REQ-021 RUN with flush_req=1 and mem_busy=1 SHALL go to FLUSH_WAIT and latch flush_pc.
REQ-022 FLUSH_WAIT SHALL output stall=6'b011111 while mem_busy=1 and go to FLUSH on the first edge where mem_busy=0.
REQ-023 FLUSH SHALL last exactly one cycle with flush=1, stall=0, new_pc=latched value, then return to RUN.
REQ-024 flush_req arriving in FLUSH_WAIT or FLUSH SHALL be ignored; the first latched flush_pc wins.
REQ-025 flush SHALL be 0 and new_pc SHALL hold its last latched value outside FLUSH.
REQ-026 stall_cnt SHALL increment on each edge where stall[2]=1, holding at 32'hFFFFFFFF.
REQ-027 flush_cnt SHALL increment on entry to FLUSH, wrapping from 16'hFFFF to 0.
REQ-028 Flush-to-flush latency SHALL be 1 cycle from the accepting edge to flush=1 when mem_busy=0.

Reset
REQ-029 rst=1 at a rising edge SHALL force state RUN, new_pc=0, stall_cnt=0, and flush_cnt=0.
REQ-030 While rst=1, stall=0 and flush=0 SHALL hold regardless of the other inputs.
REQ-031 rst during FLUSH_WAIT or FLUSH SHALL discard the pending flush; no flush pulse follows.

Structure
REQ-032 The FSM state enum and the four stall-mask constants SHALL live in the shared package cpu_pkg.
REQ-033 Load-use comparison SHALL be a combinational sub-module hazard_detect instantiated once.

Verification
REQ-034 ex_is_load=1, ex_wd=5, id_reg1_read=1, id_reg1_addr=5 -> stall=6'b000111; with ex_wd=0 -> stall=0.
REQ-035 mem_busy=1 together with stallreq_ex=1 and stallreq_id=1 -> stall=6'b011111.
REQ-036 flush_req pulse with flush_pc=32'hBFC00380 and mem_busy=0 -> next cycle flush=1, new_pc=32'hBFC00380, stall=0; flush=0 the cycle after; flush_cnt=1.
REQ-037 flush_req with mem_busy=1 held 3 cycles -> stall=6'b011111 for those cycles, then flush=1 for one cycle; a second flush_req in that window -> no second flush.
REQ-038 stallreq_id=1 for 10 cycles -> stall_cnt=10; preloaded stall_cnt=32'hFFFFFFFF -> stays saturated.
REQ-039 rst=1 asserted while in FLUSH_WAIT -> state RUN, counters 0, flush never asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: controller state and stall freeze masks.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH_WAIT,
        ST_FLUSH
    } ctrl_state_e;

    // Freeze masks: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check between the load in EX and the source operands in ID.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_wd,
    input  logic       i_reg1_read,
    input  logic [4:0] i_reg1_addr,
    input  logic       i_reg2_read,
    input  logic [4:0] i_reg2_addr,
    output logic       o_load_use
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1 = i_reg1_read && (i_reg1_addr == i_ex_wd);
    assign w_hit2 = i_reg2_read && (i_reg2_addr == i_ex_wd);

    // x0 never carries a real result, so a load into it cannot hazard
    assign o_load_use = i_ex_is_load && (i_ex_wd != 5'd0) && (w_hit1 || w_hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall priority, flush sequencing and
// performance counters.
module pipe_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mem_busy,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    input  logic        id_reg1_read,
    input  logic        id_reg2_read,
    input  logic [4:0]  id_reg1_addr,
    input  logic [4:0]  id_reg2_addr,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_wd,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    ctrl_state_e r_state;
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_load_use;
    logic [5:0]  w_stall;

    hazard_detect u_hazard (
        .i_ex_is_load (ex_is_load),
        .i_ex_wd      (ex_wd),
        .i_reg1_read  (id_reg1_read),
        .i_reg1_addr  (id_reg1_addr),
        .i_reg2_read  (id_reg2_read),
        .i_reg2_addr  (id_reg2_addr),
        .o_load_use   (w_load_use)
    );

    always_comb begin
        w_stall = STALL_NONE;
        if (!rst) begin
            unique case (r_state)
                ST_RUN: begin
                    if (mem_busy)
                        w_stall = STALL_MEM;
                    else if (stallreq_ex)
                        w_stall = STALL_EX;
                    else if (stallreq_id || w_load_use)
                        w_stall = STALL_ID;
                end
                ST_FLUSH_WAIT: begin
                    if (mem_busy)
                        w_stall = STALL_MEM;
                end
                default: w_stall = STALL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush     <= 1'b0;
            r_new_pc    <= 32'd0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_flush <= 1'b0;
            if (w_stall[2])
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            unique case (r_state)
                ST_RUN: begin
                    if (flush_req) begin
                        r_new_pc <= flush_pc;
                        if (mem_busy) begin
                            r_state <= ST_FLUSH_WAIT;
                        end else begin
                            r_state     <= ST_FLUSH;
                            r_flush     <= 1'b1;
                            r_flush_cnt <= r_flush_cnt + 16'd1;
                        end
                    end
                end
                // Later requests are dropped here; the first target wins
                ST_FLUSH_WAIT: begin
                    if (!mem_busy) begin
                        r_state     <= ST_FLUSH;
                        r_flush     <= 1'b1;
                        r_flush_cnt <= r_flush_cnt + 16'd1;
                    end
                end
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign stall     = w_stall;
    assign flush     = r_flush & ~rst;
    assign new_pc    = r_new_pc;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed checks of pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, mem_busy, flush_req;
    logic [31:0] flush_pc;
    logic        id_reg1_read, id_reg2_read;
    logic [4:0]  id_reg1_addr, id_reg2_addr;
    logic        ex_is_load;
    logic [4:0]  ex_wd;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad = 0;

    // model: a flush is either waiting for memory or being issued this cycle
    bit              m_pend;
    bit              m_fl;
    logic [31:0]     m_pc;
    longint unsigned m_scnt;
    int              m_fcnt;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .mem_busy(mem_busy), .flush_req(flush_req), .flush_pc(flush_pc),
        .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
        .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
        .ex_is_load(ex_is_load), .ex_wd(ex_wd),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_stall();
        bit lu;
        if (rst || m_fl) return 6'b000000;
        if (m_pend) return mem_busy ? 6'b011111 : 6'b000000;
        if (mem_busy) return 6'b011111;
        if (stallreq_ex) return 6'b001111;
        lu = ex_is_load && ex_wd != 0 &&
             ((id_reg1_read && id_reg1_addr == ex_wd) ||
              (id_reg2_read && id_reg2_addr == ex_wd));
        if (stallreq_id || lu) return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic tick();
        logic [5:0] s;
        s = exp_stall();
        if (rst) begin
            m_pend = 0; m_fl = 0; m_pc = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (s[2] && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (m_fl) begin
                m_fl = 0;
            end else if (m_pend) begin
                if (!mem_busy) begin
                    m_pend = 0; m_fl = 1; m_fcnt = (m_fcnt + 1) % 65536;
                end
            end else if (flush_req) begin
                m_pc = flush_pc;
                if (mem_busy) m_pend = 1;
                else begin m_fl = 1; m_fcnt = (m_fcnt + 1) % 65536; end
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        stallreq_id = 0; stallreq_ex = 0; mem_busy = 0; flush_req = 0;
        flush_pc = 0; id_reg1_read = 0; id_reg2_read = 0;
        id_reg1_addr = 0; id_reg2_addr = 0; ex_is_load = 0; ex_wd = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1; #1; tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            {stallreq_id, stallreq_ex, mem_busy, flush_req} = 4'($urandom);
            ex_is_load = 1; ex_wd = 5'd3;
            id_reg1_read = 1; id_reg1_addr = 5'd3;
            flush_pc = $urandom;
            #1;
            total++;
            if (stall !== 6'b0) begin
                bad++; $display("FAIL rst_stall got=%b want=000000", stall);
            end
            total++;
            if (flush !== 1'b0) begin
                bad++; $display("FAIL rst_flush got=%b want=0", flush);
            end
            tick();
        end
        quiet(); rst = 0; #1;
        total++;
        if (new_pc !== 0 || stall_cnt !== 0 || flush_cnt !== 0) begin
            bad++;
            $display("FAIL rst_state got pc=%h sc=%0d fc=%0d want 0/0/0",
                     new_pc, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        quiet();
        ex_is_load = 1; ex_wd = 5; id_reg1_read = 1; id_reg1_addr = 5; #1;
        total++;
        if (stall !== 6'b000111) begin
            bad++; $display("FAIL load_use got=%b want=000111", stall);
        end
        ex_wd = 0; id_reg1_addr = 0; #1;
        total++;
        if (stall !== 6'b000000) begin
            bad++; $display("FAIL load_use_x0 got=%b want=000000", stall);
        end
        ex_wd = 9; id_reg1_read = 0; id_reg1_addr = 9;
        id_reg2_read = 1; id_reg2_addr = 9; #1;
        total++;
        if (stall !== 6'b000111) begin
            bad++; $display("FAIL load_use_rs2 got=%b want=000111", stall);
        end
        id_reg2_read = 0; #1;
        total++;
        if (stall !== 6'b000000) begin
            bad++; $display("FAIL load_use_noread got=%b want=000000", stall);
        end
        tick();
        for (int i = 0; i < 60; i++) begin
            quiet();
            ex_is_load = 1'($urandom);
            ex_wd = 5'($urandom_range(0, 3));
            id_reg1_read = 1'($urandom); id_reg2_read = 1'($urandom);
            id_reg1_addr = 5'($urandom_range(0, 3));
            id_reg2_addr = 5'($urandom_range(0, 3));
            #1;
            total++;
            if (stall !== exp_stall()) begin
                bad++;
                $display("FAIL load_use_rand got=%b want=%b", stall, exp_stall());
            end
            tick();
        end
    endtask

    task automatic test_priority();
        quiet();
        mem_busy = 1; stallreq_ex = 1; stallreq_id = 1; #1;
        total++;
        if (stall !== 6'b011111) begin
            bad++; $display("FAIL prio_all got=%b want=011111", stall);
        end
        mem_busy = 0; #1;
        total++;
        if (stall !== 6'b001111) begin
            bad++; $display("FAIL prio_ex got=%b want=001111", stall);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            {mem_busy, stallreq_ex, stallreq_id} = 3'($urandom);
            #1;
            total++;
            if (stall !== exp_stall()) begin
                bad++;
                $display("FAIL prio_rand got=%b want=%b", stall, exp_stall());
            end
            tick();
        end
        quiet();
    endtask

    task automatic test_flush_nobusy();
        do_reset();
        flush_req = 1; flush_pc = 32'hBFC00380; #1;
        total++;
        if (flush !== 1'b0) begin
            bad++; $display("FAIL fl_accept_cycle got=%b want=0", flush);
        end
        tick();
        flush_req = 0; flush_pc = 0; #1;
        total++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00380 || stall !== 6'b0) begin
            bad++;
            $display("FAIL fl_pulse got f=%b pc=%h s=%b want 1/bfc00380/0",
                     flush, new_pc, stall);
        end
        tick(); #1;
        total++;
        if (flush !== 1'b0 || flush_cnt !== 16'd1 || new_pc !== 32'hBFC00380) begin
            bad++;
            $display("FAIL fl_after got f=%b fc=%0d pc=%h want 0/1/bfc00380",
                     flush, flush_cnt, new_pc);
        end
    endtask

    task automatic test_flush_busy();
        int nfl;
        do_reset();
        nfl = 0;
        flush_req = 1; flush_pc = 32'h8000_0100; mem_busy = 1;
        #1; tick();
        for (int i = 0; i < 3; i++) begin
            flush_req = (i == 1); flush_pc = 32'hDEAD_0000;
            mem_busy = (i < 2);
            #1;
            if (i < 2) begin
                total++;
                if (stall !== 6'b011111 || flush !== 1'b0) begin
                    bad++;
                    $display("FAIL fl_wait got s=%b f=%b want 011111/0", stall, flush);
                end
            end
            tick();
        end
        quiet();
        for (int i = 0; i < 4; i++) begin
            #1;
            if (flush) nfl++;
            if (i == 0) begin
                total++;
                if (flush !== 1'b1 || new_pc !== 32'h8000_0100) begin
                    bad++;
                    $display("FAIL fl_wait_pulse got f=%b pc=%h want 1/80000100",
                             flush, new_pc);
                end
            end
            tick();
        end
        total++;
        if (nfl != 1 || flush_cnt !== 16'd1) begin
            bad++;
            $display("FAIL fl_single got pulses=%0d fc=%0d want 1/1", nfl, flush_cnt);
        end
    endtask

    task automatic test_stall_cnt();
        do_reset();
        stallreq_id = 1;
        repeat (10) begin #1; tick(); end
        quiet(); #1;
        total++;
        if (stall_cnt !== 32'd10) begin
            bad++; $display("FAIL scnt_10 got=%0d want=10", stall_cnt);
        end
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        m_scnt = 64'hFFFF_FFFE;
        stallreq_id = 1;
        repeat (3) begin #1; tick(); end
        quiet(); #1;
        total++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL scnt_sat got=%h want=ffffffff", stall_cnt);
        end
    endtask

    task automatic test_rst_in_wait();
        int nfl;
        do_reset();
        stallreq_id = 1; #1; tick();
        quiet();
        flush_req = 1; flush_pc = 32'h1234_5678; mem_busy = 1; #1; tick();
        flush_req = 0; rst = 1; mem_busy = 0; #1;
        total++;
        if (stall !== 6'b0 || flush !== 1'b0) begin
            bad++; $display("FAIL rstw_during got s=%b f=%b want 0/0", stall, flush);
        end
        tick();
        rst = 0; nfl = 0;
        for (int i = 0; i < 4; i++) begin
            #1; if (flush) nfl++; tick();
        end
        total++;
        if (nfl != 0 || stall_cnt !== 0 || flush_cnt !== 0 || new_pc !== 0) begin
            bad++;
            $display("FAIL rstw_after got pulses=%0d sc=%0d fc=%0d pc=%h want 0",
                     nfl, stall_cnt, flush_cnt, new_pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            stallreq_id = ($urandom_range(0, 5) == 0);
            stallreq_ex = ($urandom_range(0, 7) == 0);
            mem_busy = ($urandom_range(0, 2) == 0);
            flush_req = ($urandom_range(0, 6) == 0);
            flush_pc = $urandom;
            ex_is_load = 1'($urandom);
            ex_wd = 5'($urandom_range(0, 3));
            id_reg1_read = 1'($urandom); id_reg2_read = 1'($urandom);
            id_reg1_addr = 5'($urandom_range(0, 3));
            id_reg2_addr = 5'($urandom_range(0, 3));
            #1;
            total++;
            if (stall !== exp_stall() || flush !== (m_fl && !rst)) begin
                bad++;
                $display("FAIL rand_out cyc=%0d got s=%b f=%b want s=%b f=%b",
                         i, stall, flush, exp_stall(), m_fl && !rst);
            end
            total++;
            if (new_pc !== m_pc || stall_cnt !== m_scnt[31:0] ||
                flush_cnt !== 16'(m_fcnt)) begin
                bad++;
                $display("FAIL rand_state cyc=%0d got pc=%h sc=%0d fc=%0d want pc=%h sc=%0d fc=%0d",
                         i, new_pc, stall_cnt, flush_cnt, m_pc, m_scnt, m_fcnt);
            end
            tick();
        end
        rst = 0; quiet();
    endtask

    initial begin
        quiet();
        rst = 1;
        m_pend = 0; m_fl = 0; m_pc = 0; m_scnt = 0; m_fcnt = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_priority();
        test_flush_nobusy();
        test_flush_busy();
        test_stall_cnt();
        test_rst_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
